// File: rtl/parking_count_sequencer.sv
// Parking occupancy counter: entry/exit requests applied serially, LSB-first, through one shared add/sub cell.
// Latency: ack and new count in cycle WIDTH+1 after grant; deny in cycle 1. Requests are level-held until ack/deny.
// CAPACITY_CHECK_EN enables full/empty deny; without it the count wraps modulo 2^WIDTH.

module parking_addsub_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sel,
  output logic sum,
  output logic cout
);
  logic bx;
  assign bx   = b ^ sel;
  assign sum  = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

module parking_count_sequencer #(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_ack,
  output logic             exit_ack,
  output logic             entry_deny,
  output logic             exit_deny,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] CAP      = WIDTH'(CAPACITY);
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, DENY} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic             op;          // 0 = increment, 1 = decrement
  logic [BW-1:0]    bitcnt;
  logic             last_entry;  // last served/denied requester was entry

  logic any_req, pick_entry, eligible;
  logic cell_sum, cell_cout;

  assign full  = (count == CAP);
  assign empty = (count == '0);

  // Tie goes to whichever side was not served last.
  assign any_req    = entry_req | exit_req;
  assign pick_entry = entry_req & (~exit_req | ~last_entry);

`ifdef CAPACITY_CHECK_EN
  assign eligible = pick_entry ? ~full : ~empty;
`else
  assign eligible   = 1'b1;
  assign entry_deny = 1'b0;
  assign exit_deny  = 1'b0;
`endif

  // b is the constant 1 presented LSB-first; sel inverts it and carry-in starts at op for subtraction.
  parking_addsub_cell u_cell (
    .a    (sr[0]),
    .b    (bitcnt == '0),
    .cin  (carry),
    .sel  (op),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      carry      <= 1'b0;
      op         <= 1'b0;
      bitcnt     <= '0;
      last_entry <= 1'b0;
      busy       <= 1'b0;
      entry_ack  <= 1'b0;
      exit_ack   <= 1'b0;
`ifdef CAPACITY_CHECK_EN
      entry_deny <= 1'b0;
      exit_deny  <= 1'b0;
`endif
    end else begin
      entry_ack <= 1'b0;
      exit_ack  <= 1'b0;
`ifdef CAPACITY_CHECK_EN
      entry_deny <= 1'b0;
      exit_deny  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            last_entry <= pick_entry;
            op         <= ~pick_entry;
            if (eligible) begin
              sr     <= count;
              carry  <= ~pick_entry;
              bitcnt <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
`ifdef CAPACITY_CHECK_EN
              entry_deny <= pick_entry;
              exit_deny  <= ~pick_entry;
`endif
              state <= DENY;
            end
          end
        end
        RUN: begin
          sr     <= {cell_sum, sr[WIDTH-1:1]};
          carry  <= cell_cout;
          bitcnt <= bitcnt + BW'(1);
          if (bitcnt == LAST_BIT) begin
            // Commit on the way into DONE so count and ack are visible in the same cycle.
            count     <= {cell_sum, sr[WIDTH-1:1]};
            entry_ack <= ~op;
            exit_ack  <= op;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        DENY:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parking_count_sequencer.sv
// Directed bench for parking_count_sequencer with a scoreboard queue of expected ack/deny events.
module tb_parking_count_sequencer;
  localparam int W   = 8;
  localparam int CAP = 12;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         entry_req, exit_req;
  logic         entry_ack, exit_ack, entry_deny, exit_deny, busy, full, empty;
  logic [W-1:0] count;

  always #5 clk = ~clk;

  parking_count_sequencer #(.WIDTH(W), .CAPACITY(CAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .entry_ack  (entry_ack),
    .exit_ack   (exit_ack),
    .entry_deny (entry_deny),
    .exit_deny  (exit_deny),
    .busy       (busy),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  typedef struct {
    logic [3:0]   kind;  // {exit_deny, entry_deny, exit_ack, entry_ack}
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   model_count = 0;
  bit   model_last_entry = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void predict(input bit is_entry);
    exp_t e;
    bit   ok;
`ifdef CAPACITY_CHECK_EN
    ok = is_entry ? (model_count != CAP) : (model_count != 0);
`else
    ok = 1'b1;
`endif
    if (ok) model_count = is_entry ? (model_count + 1) % MOD : (model_count + MOD - 1) % MOD;
    e.kind = ok ? (is_entry ? 4'b0001 : 4'b0010) : (is_entry ? 4'b0100 : 4'b1000);
    e.cnt  = W'(model_count);
    sb.push_back(e);
    model_last_entry = is_entry;
  endfunction

  function automatic logic [3:0] pulses();
    return {exit_deny, entry_deny, exit_ack, entry_ack};
  endfunction

  task automatic serve(input bit e, input bit x);
    exp_t       ex;
    logic [3:0] obs;
    if (e && x) begin
      if (!model_last_entry) begin predict(1'b1); predict(1'b0); end
      else begin predict(1'b0); predict(1'b1); end
    end else begin
      predict(e);
    end
    entry_req = e;
    exit_req  = x;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      @(posedge clk); #1;
      obs = pulses();
      if (obs != 4'b0) begin
        ex = sb.pop_front();
        check("pulse_kind", 32'(obs), 32'(ex.kind));
        check("count", 32'(count), 32'(ex.cnt));
        check("full", 32'(full), 32'(ex.cnt == W'(CAP)));
        check("empty", 32'(empty), 32'(ex.cnt == '0));
        if (obs[0] | obs[2]) entry_req = 1'b0;
        if (obs[1] | obs[3]) exit_req = 1'b0;
        @(posedge clk); #1;
        check("pulse_width", 32'(pulses()), 32'd0);
      end
    end
    if (sb.size() != 0) begin
      check("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_count = 0;
    model_last_entry = 1'b0;
    sb.delete();
  endtask

  initial begin
    exp_t ex;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'(pulses()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First entry with cycle-accurate latency: busy in cycles 1..W, ack in W+1.
    predict(1'b1);
    entry_req = 1'b1;
    for (int c = 1; c <= W; c++) begin
      @(posedge clk); #1;
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_no_ack", 32'(pulses()), 32'd0);
      check("lat_count_hold", 32'(count), 32'd0);
    end
    @(posedge clk); #1;
    ex = sb.pop_front();
    check("lat_ack", 32'(pulses()), 32'(ex.kind));
    check("lat_busy_low", 32'(busy), 32'd0);
    check("lat_count", 32'(count), 32'(ex.cnt));
    check("lat_empty", 32'(empty), 32'd0);
    entry_req = 1'b0;
    @(posedge clk); #1;
    check("lat_pulse_width", 32'(pulses()), 32'd0);

    // Up to 6, back to 5 so exit was served last and entry wins the tie.
    for (int i = 0; i < 5; i++) serve(1'b1, 1'b0);
    serve(1'b0, 1'b1);
    check("pre_tie_count", 32'(count), 32'd5);
    serve(1'b1, 1'b1);
    check("post_tie_count", 32'(count), 32'd5);

    for (int i = 0; i < 5; i++) serve(1'b1, 1'b0);
    check("pre_alt_count", 32'(count), 32'd10);
    for (int i = 0; i < 20; i++) serve(i % 2 == 0, i % 2 == 1);
    check("post_alt_count", 32'(count), 32'd10);

    // Fill to capacity, then one more entry.
    for (int i = 0; i < 2; i++) serve(1'b1, 1'b0);
    check("at_cap_full", 32'(full), 32'd1);
    serve(1'b1, 1'b0);

    // Reset during bit 4 of an increment from 7.
    reset_dut();
    for (int i = 0; i < 7; i++) serve(1'b1, 1'b0);
    check("pre_abort_count", 32'(count), 32'd7);
    entry_req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_count", 32'(count), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    entry_req = 1'b0;
    model_count = 0;
    model_last_entry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_ack", 32'(pulses()), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_count", 32'(count), 32'd0);
    check("abort_idle_pulses", 32'(pulses()), 32'd0);

    // Exit at empty, then entry: deny path or wrap depending on build.
    serve(1'b0, 1'b1);
    serve(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parking_count_sequencer.md
# parking_count_sequencer

Bit-serial occupancy counter controller for the parking lot. It arbitrates entry-gate and exit-gate update requests onto one shared one-bit add/sub full-adder cell (a, b, cin, sel -> sum, cout; sel=1 inverts b for subtraction). Each request is sequenced through that cell LSB-first over WIDTH cycles to increment or decrement the stored occupancy count. It sits between the gate sensor logic and the display/status logic.

## Interface
- WIDTH, 8: occupancy count width in bits (>= 2).
- CAPACITY, 200: maximum number of cars; must satisfy 1 <= CAPACITY <= 2^WIDTH-1.

- clk  in  1  rising-edge system clock.
- rst_n  in  1  asynchronous, active-low reset.
- entry_req  in  1  level request: one car entered; held until entry_ack or entry_deny.
- exit_req  in  1  level request: one car left; held until exit_ack or exit_deny.
- entry_ack  out  1  one-cycle pulse: increment committed.
- exit_ack  out  1  one-cycle pulse: decrement committed.
- entry_deny  out  1  one-cycle pulse: entry refused because the lot is full.
- exit_deny  out  1  one-cycle pulse: exit refused because the lot is empty.
- busy  out  1  high while a serial update is in progress (RUN state).
- count  out  WIDTH  committed occupancy; changes only on the ack cycle.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.

## Operation
- States: IDLE, RUN, DONE, DENY.
- IDLE, when at least one request is pending, one requester is selected:
  - If only one request is pending, it is selected.
  - If both are pending, the requester not served last is selected. The last-served flag resets to "exit", so entry wins the first tie.
  - The last-served flag updates on every grant or deny.
- IDLE, selected request eligible: load the shift register with count, load carry with op (0=add, 1=sub), load bit counter with 0, go to RUN.
- IDLE, selected request ineligible (entry while full, or exit while empty): go to DENY.
- RUN: one bit per cycle through the shared cell.
  - Cell inputs: a = shift register LSB; b = 1 on bit 0 and 0 otherwise; cin = carry register; sel = op.
  - sum is shifted into the shift register MSB and cout is registered as the next carry.
  - After bit WIDTH-1 is processed, go to DONE.
- DONE: count <= shift register; pulse the ack for the served requester; go to IDLE.
- DENY: pulse the deny for the selected requester; count is unchanged; go to IDLE.
- Arithmetic is modulo 2^WIDTH. The final cout is discarded.
- full and empty are combinational decodes of the committed count.
- Requests arriving while not in IDLE are held by the requester and evaluated at the next IDLE. They are never dropped.

## Timing
- Reset values:
  - State = IDLE, count = 0, last-served = exit.
  - All ack, deny and busy outputs = 0.
  - empty = 1, full = 0.
- Reset asserted mid-RUN aborts the update. count returns to 0 immediately, with no ack.
- Latency for a request sampled in IDLE at edge 0:
  - busy is high for cycles 1..WIDTH.
  - ack and the new count appear in cycle WIDTH+1.
  - The next request is sampled at edge WIDTH+2.
- Deny latency: deny is high in cycle 1; the next request is sampled at edge 2.
- Handshake: the requester must drop its request on the edge that ends its ack or deny cycle. A request still high in IDLE is treated as a new event.
- A simultaneous entry and exit are serialized. The net count changes by 0 after both complete, taking 2*(WIDTH+2) cycles.

## Configuration
- Macro: CAPACITY_CHECK_EN.
- Defined: the deny path is active as described above.
- Undefined:
  - DENY is never entered and every request is served.
  - count wraps modulo 2^WIDTH (e.g. 0 - 1 = 2^WIDTH-1).
  - entry_deny and exit_deny are tied to 0.
  - full and empty are still driven.

## Test plan
- Reset, then a single entry_req with WIDTH=8 -> busy for 8 cycles, entry_ack in cycle 9, count=1, empty falls.
- From count=5, assert entry_req and exit_req together -> entry served first (ack in cycle 9, count=6), then exit (count=5); no request lost.
- With CAPACITY=3 and count=3, assert entry_req -> entry_deny in cycle 1, count stays 3, full=1. Exit at count=0 -> exit_deny.
- With the macro undefined, exit at count=0 -> exit_ack, count=255. Entry at 255 -> count=0.
- Assert rst_n low during bit 4 of an increment from count=7 -> count=0 immediately, no ack, state IDLE.
- 20 back-to-back alternating entry/exit requests from count=10 -> count ends at 10. Check each ack is a single-cycle pulse.
